// File: rtl/ieu_rs_pkg.sv
// Defaults and bit-vector helpers for the IEU reservation station.
// Latency: n/a (pure functions).
// Backpressure: n/a.
package ieu_rs_pkg;

    localparam int RS_DATA_WIDTH_DFLT    = 32;
    localparam int RS_ADDR_WIDTH_DFLT    = 32;
    localparam int RS_ROB_IDX_WIDTH_DFLT = 5;
    localparam int RS_DEPTH_DFLT         = 4;

    // Helpers operate on a fixed maximum width; callers zero-extend.
    localparam int RS_MAX_DEPTH  = 32;
    localparam int RS_MAX_IDX_W  = $clog2(RS_MAX_DEPTH);

    // One-hot of the lowest set bit (zero if none set).
    function automatic logic [RS_MAX_DEPTH-1:0] lowest_set(input logic [RS_MAX_DEPTH-1:0] v);
        return v & (~v + 32'd1);
    endfunction

    // Binary index of a one-hot vector (zero if none set).
    function automatic logic [RS_MAX_IDX_W-1:0] oh_to_idx(input logic [RS_MAX_DEPTH-1:0] oh);
        logic [RS_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < RS_MAX_DEPTH; i++) begin
            if (oh[i]) idx = idx | RS_MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ieu_rs_age_matrix.sv
// Age matrix picking the oldest ready RS entry as a one-hot grant.
// Latency: grant is combinational from ready and registered age state.
// Backpressure: none; a grant is produced whenever any entry is ready.
//
// Ports: clk; dispatch_oh (slot written this edge); valid, ready (per entry);
//        grant (one-hot oldest ready entry, zero if none ready).
module ieu_rs_age_matrix
    import ieu_rs_pkg::*;
#(
    parameter int OPTN_RS_DEPTH = RS_DEPTH_DFLT
) (
    input  logic                     clk,
    input  logic [OPTN_RS_DEPTH-1:0] dispatch_oh,
    input  logic [OPTN_RS_DEPTH-1:0] valid,
    input  logic [OPTN_RS_DEPTH-1:0] ready,
    output logic [OPTN_RS_DEPTH-1:0] grant
);

    // age_q[i][j] = 1 means entry i is older than entry j. Not reset: a row is
    // rewritten whenever its slot is dispatched, and only valid rows are read.
    logic [OPTN_RS_DEPTH-1:0] age_q [OPTN_RS_DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < OPTN_RS_DEPTH; i++) begin
            if (dispatch_oh[i]) begin
                age_q[i] <= '0;
            end else if (valid[i]) begin
                age_q[i] <= age_q[i] | dispatch_oh;
            end
        end
    end

    // An entry wins if it is ready and no other ready entry is older than it.
    always_comb begin
        grant = '0;
        for (int i = 0; i < OPTN_RS_DEPTH; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < OPTN_RS_DEPTH; j++) begin
                if ((j != i) && ready[j] && age_q[j][i]) grant[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/procyon_constants.svh
// Shared Procyon core macros: opcode width, RS index width, IEU RS entry layout.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
`ifndef PROCYON_CONSTANTS_SVH
`define PROCYON_CONSTANTS_SVH

`define PCYN_OPCODE_WIDTH 8

// Index width for an RS of the given depth; never narrower than one bit.
`define PCYN_RS_IDX_WIDTH(depth) (((depth) > 1) ? $clog2(depth) : 1)

// Entry layout depends on the instantiating module's widths, so the typedef
// is expanded inside that module with its own parameters.
`define PCYN_IEU_RS_ENTRY_T(dw, aw, tw) \
    typedef struct packed { \
        logic                          valid; \
        logic [`PCYN_OPCODE_WIDTH-1:0] opcode; \
        logic [(aw)-1:0]               iaddr; \
        logic [(dw)-1:0]               insn; \
        logic [(tw)-1:0]               dst_tag; \
        logic                          src_a_rdy; \
        logic [(tw)-1:0]               src_a_tag; \
        logic [(dw)-1:0]               src_a_data; \
        logic                          src_b_rdy; \
        logic [(tw)-1:0]               src_b_tag; \
        logic [(dw)-1:0]               src_b_data; \
    } ieu_rs_entry_t;

`endif

// File: rtl/ieu_rs.sv
// Integer reservation station: holds renamed ops until operands arrive via CDB, issues oldest ready.
// Latency: dispatch-to-issue 2 edges minimum; CDB wakeup-to-issue 2 edges.
// Backpressure: o_rs_stall while every entry is valid; no backpressure from the IEU.
//
// Ports: clk/rst (sync, active high); i_flush; dispatch i_rs_* with o_rs_stall;
//        CDB snoop i_cdb_*; issued op o_opcode/o_iaddr/o_insn/o_src_a/o_src_b/o_tag + o_valid.
`include "procyon_constants.svh"

module ieu_rs
    import ieu_rs_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH    = RS_DATA_WIDTH_DFLT,
    parameter int OPTN_ADDR_WIDTH    = RS_ADDR_WIDTH_DFLT,
    parameter int OPTN_ROB_IDX_WIDTH = RS_ROB_IDX_WIDTH_DFLT,
    parameter int OPTN_RS_DEPTH      = RS_DEPTH_DFLT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,

    input  logic                          i_rs_en,
    input  logic [`PCYN_OPCODE_WIDTH-1:0] i_rs_opcode,
    input  logic [OPTN_ADDR_WIDTH-1:0]    i_rs_iaddr,
    input  logic [OPTN_DATA_WIDTH-1:0]    i_rs_insn,
    input  logic [OPTN_DATA_WIDTH-1:0]    i_rs_src_a_data,
    input  logic [OPTN_DATA_WIDTH-1:0]    i_rs_src_b_data,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_rs_src_a_tag,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_rs_src_b_tag,
    input  logic                          i_rs_src_a_rdy,
    input  logic                          i_rs_src_b_rdy,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_rs_dst_tag,
    output logic                          o_rs_stall,

    input  logic                          i_cdb_en,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_cdb_tag,
    input  logic [OPTN_DATA_WIDTH-1:0]    i_cdb_data,

    output logic [`PCYN_OPCODE_WIDTH-1:0] o_opcode,
    output logic [OPTN_ADDR_WIDTH-1:0]    o_iaddr,
    output logic [OPTN_DATA_WIDTH-1:0]    o_insn,
    output logic [OPTN_DATA_WIDTH-1:0]    o_src_a,
    output logic [OPTN_DATA_WIDTH-1:0]    o_src_b,
    output logic [OPTN_ROB_IDX_WIDTH-1:0] o_tag,
    output logic                          o_valid
);

    localparam int RS_IDX_WIDTH = `PCYN_RS_IDX_WIDTH(OPTN_RS_DEPTH);

    `PCYN_IEU_RS_ENTRY_T(OPTN_DATA_WIDTH, OPTN_ADDR_WIDTH, OPTN_ROB_IDX_WIDTH)

    ieu_rs_entry_t               entries [OPTN_RS_DEPTH];
    ieu_rs_entry_t               new_entry;
    logic [OPTN_RS_DEPTH-1:0]    valid_vec;
    logic [OPTN_RS_DEPTH-1:0]    ready_vec;
    logic [OPTN_RS_DEPTH-1:0]    free_vec;
    logic [OPTN_RS_DEPTH-1:0]    disp_slot;
    logic [OPTN_RS_DEPTH-1:0]    disp_oh;
    logic [OPTN_RS_DEPTH-1:0]    grant;
    logic [RS_IDX_WIDTH-1:0]     sel_idx;
    logic                        disp_fire;

    // Readiness looks only at registered state, so a CDB wakeup becomes
    // eligible for select one cycle after the broadcast.
    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int i = 0; i < OPTN_RS_DEPTH; i++) begin
            valid_vec[i] = entries[i].valid;
            ready_vec[i] = entries[i].valid & entries[i].src_a_rdy & entries[i].src_b_rdy;
        end
    end

    // Conservative full: a same-cycle issue does not free a slot for dispatch.
    assign o_rs_stall = &valid_vec;

    // Dispatch is dropped in a reset/flush cycle so the age matrix stays clean.
    assign disp_fire = i_rs_en & ~o_rs_stall & ~i_flush & ~rst;
    assign free_vec  = ~valid_vec;
    assign disp_slot = OPTN_RS_DEPTH'(lowest_set(RS_MAX_DEPTH'(free_vec)));
    assign disp_oh   = disp_fire ? disp_slot : '0;
    assign sel_idx   = RS_IDX_WIDTH'(oh_to_idx(RS_MAX_DEPTH'(grant)));

    // Incoming op, with a same-cycle CDB bypass for sources still waiting.
    always_comb begin
        new_entry            = '0;
        new_entry.valid      = 1'b1;
        new_entry.opcode     = i_rs_opcode;
        new_entry.iaddr      = i_rs_iaddr;
        new_entry.insn       = i_rs_insn;
        new_entry.dst_tag    = i_rs_dst_tag;
        new_entry.src_a_tag  = i_rs_src_a_tag;
        new_entry.src_b_tag  = i_rs_src_b_tag;
        new_entry.src_a_rdy  = i_rs_src_a_rdy;
        new_entry.src_b_rdy  = i_rs_src_b_rdy;
        new_entry.src_a_data = i_rs_src_a_data;
        new_entry.src_b_data = i_rs_src_b_data;
        if (!i_rs_src_a_rdy && i_cdb_en && (i_rs_src_a_tag == i_cdb_tag)) begin
            new_entry.src_a_rdy  = 1'b1;
            new_entry.src_a_data = i_cdb_data;
        end
        if (!i_rs_src_b_rdy && i_cdb_en && (i_rs_src_b_tag == i_cdb_tag)) begin
            new_entry.src_b_rdy  = 1'b1;
            new_entry.src_b_data = i_cdb_data;
        end
    end

    ieu_rs_age_matrix #(
        .OPTN_RS_DEPTH (OPTN_RS_DEPTH)
    ) u_age_matrix (
        .clk         (clk),
        .dispatch_oh (disp_oh),
        .valid       (valid_vec),
        .ready       (ready_vec),
        .grant       (grant)
    );

    // Only valid bits and o_valid are cleared on reset/flush; payload and the
    // issued op fields are don't-care while their valid is low.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int i = 0; i < OPTN_RS_DEPTH; i++) entries[i].valid <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            for (int i = 0; i < OPTN_RS_DEPTH; i++) begin
                if (disp_oh[i]) begin
                    entries[i] <= new_entry;
                end else begin
                    if (entries[i].valid && !entries[i].src_a_rdy && i_cdb_en &&
                        (entries[i].src_a_tag == i_cdb_tag)) begin
                        entries[i].src_a_rdy  <= 1'b1;
                        entries[i].src_a_data <= i_cdb_data;
                    end
                    if (entries[i].valid && !entries[i].src_b_rdy && i_cdb_en &&
                        (entries[i].src_b_tag == i_cdb_tag)) begin
                        entries[i].src_b_rdy  <= 1'b1;
                        entries[i].src_b_data <= i_cdb_data;
                    end
                    if (grant[i]) entries[i].valid <= 1'b0;
                end
            end

            o_valid <= |grant;
            if (|grant) begin
                o_opcode <= entries[sel_idx].opcode;
                o_iaddr  <= entries[sel_idx].iaddr;
                o_insn   <= entries[sel_idx].insn;
                o_src_a  <= entries[sel_idx].src_a_data;
                o_src_b  <= entries[sel_idx].src_b_data;
                o_tag    <= entries[sel_idx].dst_tag;
            end
        end
    end

endmodule

// File: tb/tb_ieu_rs.sv
// Directed bench for ieu_rs with an in-order issue scoreboard.
// Latency: checks exact issue cycles relative to dispatch and CDB broadcasts.
// Backpressure: exercises o_rs_stall and dispatch-while-full being ignored.
module tb_ieu_rs;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TW = 5;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_flush;
    logic          i_rs_en;
    logic [OW-1:0] i_rs_opcode;
    logic [AW-1:0] i_rs_iaddr;
    logic [DW-1:0] i_rs_insn;
    logic [DW-1:0] i_rs_src_a_data;
    logic [DW-1:0] i_rs_src_b_data;
    logic [TW-1:0] i_rs_src_a_tag;
    logic [TW-1:0] i_rs_src_b_tag;
    logic          i_rs_src_a_rdy;
    logic          i_rs_src_b_rdy;
    logic [TW-1:0] i_rs_dst_tag;
    logic          o_rs_stall;
    logic          i_cdb_en;
    logic [TW-1:0] i_cdb_tag;
    logic [DW-1:0] i_cdb_data;
    logic [OW-1:0] o_opcode;
    logic [AW-1:0] o_iaddr;
    logic [DW-1:0] o_insn;
    logic [DW-1:0] o_src_a;
    logic [DW-1:0] o_src_b;
    logic [TW-1:0] o_tag;
    logic          o_valid;

    always #5 clk = ~clk;

    ieu_rs #(
        .OPTN_DATA_WIDTH    (DW),
        .OPTN_ADDR_WIDTH    (AW),
        .OPTN_ROB_IDX_WIDTH (TW),
        .OPTN_RS_DEPTH      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_flush         (i_flush),
        .i_rs_en         (i_rs_en),
        .i_rs_opcode     (i_rs_opcode),
        .i_rs_iaddr      (i_rs_iaddr),
        .i_rs_insn       (i_rs_insn),
        .i_rs_src_a_data (i_rs_src_a_data),
        .i_rs_src_b_data (i_rs_src_b_data),
        .i_rs_src_a_tag  (i_rs_src_a_tag),
        .i_rs_src_b_tag  (i_rs_src_b_tag),
        .i_rs_src_a_rdy  (i_rs_src_a_rdy),
        .i_rs_src_b_rdy  (i_rs_src_b_rdy),
        .i_rs_dst_tag    (i_rs_dst_tag),
        .o_rs_stall      (o_rs_stall),
        .i_cdb_en        (i_cdb_en),
        .i_cdb_tag       (i_cdb_tag),
        .i_cdb_data      (i_cdb_data),
        .o_opcode        (o_opcode),
        .o_iaddr         (o_iaddr),
        .o_insn          (o_insn),
        .o_src_a         (o_src_a),
        .o_src_b         (o_src_b),
        .o_tag           (o_tag),
        .o_valid         (o_valid)
    );

    typedef struct packed {
        logic [OW-1:0] opcode;
        logic [AW-1:0] iaddr;
        logic [DW-1:0] insn;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [TW-1:0] tag;
    } op_t;

    op_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic chk1(input string name, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", name, obs, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic chkop(input string name, input op_t obs, input op_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed tag=%0d a=0x%0h b=0x%0h op=0x%0h ia=0x%0h insn=0x%0h expected tag=%0d a=0x%0h b=0x%0h op=0x%0h ia=0x%0h insn=0x%0h",
                   name, obs.tag, obs.a, obs.b, obs.opcode, obs.iaddr, obs.insn,
                   exp.tag, exp.a, exp.b, exp.opcode, exp.iaddr, exp.insn);
        end
    endtask

    // Opcode/address/instruction are derived from the destination tag so the
    // whole issued payload can be predicted.
    function automatic op_t mk_op(input logic [TW-1:0] tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
        op_t e;
        e.opcode = OW'(tag) + 8'h40;
        e.iaddr  = 32'h1000 + 32'(tag) * 32'd4;
        e.insn   = 32'hABCD_0000 | 32'(tag);
        e.a      = a;
        e.b      = b;
        e.tag    = tag;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_rs_en  = 1'b0;
        i_cdb_en = 1'b0;
        i_flush  = 1'b0;
    endtask

    task automatic drive_disp(input logic [TW-1:0] tag,
                              input logic ar, input logic [DW-1:0] av, input logic [TW-1:0] at,
                              input logic br, input logic [DW-1:0] bv, input logic [TW-1:0] bt);
        op_t e;
        e = mk_op(tag, av, bv);
        i_rs_en         = 1'b1;
        i_rs_opcode     = e.opcode;
        i_rs_iaddr      = e.iaddr;
        i_rs_insn       = e.insn;
        i_rs_dst_tag    = tag;
        i_rs_src_a_rdy  = ar;
        i_rs_src_a_data = ar ? av : 32'hDEAD_BEEF;
        i_rs_src_a_tag  = at;
        i_rs_src_b_rdy  = br;
        i_rs_src_b_data = br ? bv : 32'hDEAD_BEEF;
        i_rs_src_b_tag  = bt;
    endtask

    task automatic drive_cdb(input logic [TW-1:0] tag, input logic [DW-1:0] data);
        i_cdb_en   = 1'b1;
        i_cdb_tag  = tag;
        i_cdb_data = data;
    endtask

    // Every issue must match the head of the scoreboard; an issue with an
    // empty scoreboard is a spurious issue.
    always @(negedge clk) begin : monitor
        op_t obs;
        op_t exp_op;
        if (mon_en && (o_valid === 1'b1)) begin
            chk1("spurious_issue", o_valid, sb.size() != 0);
            if (sb.size() != 0) begin
                exp_op = sb.pop_front();
                obs    = {o_opcode, o_iaddr, o_insn, o_src_a, o_src_b, o_tag};
                chkop("issue_payload", obs, exp_op);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        drive_disp(0, 1'b0, 0, 0, 1'b0, 0, 0);
        i_rs_en = 1'b0;
        drive_cdb(0, 0);
        i_cdb_en = 1'b0;
        step();
        step();
        rst    = 1'b0;
        mon_en = 1'b1;
        chk1("reset_o_valid", o_valid, 1'b0);
        chk1("reset_stall", o_rs_stall, 1'b0);

        // Both sources ready: issue exactly two edges after dispatch.
        drive_disp(3, 1'b1, 5, 0, 1'b1, 7, 0);
        sb.push_back(mk_op(3, 5, 7));
        step(); idle();
        chk1("t1_not_yet", o_valid, 1'b0);
        step();
        chk1("t1_valid", o_valid, 1'b1);
        chk32("t1_tag", 32'(o_tag), 32'd3);
        chk32("t1_src_a", o_src_a, 32'd5);
        chk32("t1_src_b", o_src_b, 32'd7);
        step();
        chk1("t1_valid_drop", o_valid, 1'b0);

        // src_a waits on tag 9, broadcast two cycles after dispatch.
        drive_disp(4, 1'b0, 0, 9, 1'b1, 2, 0);
        step(); idle();
        step();
        chk1("t2_waiting", o_valid, 1'b0);
        drive_cdb(9, 32'h1234);
        sb.push_back(mk_op(4, 32'h1234, 2));
        step(); idle();
        chk1("t2_wake_edge", o_valid, 1'b0);
        step();
        chk1("t2_issue", o_valid, 1'b1);
        chk32("t2_src_a", o_src_a, 32'h1234);
        step();

        // Three ops woken by one broadcast issue oldest first.
        for (int t = 1; t <= 3; t++) begin
            drive_disp(TW'(t), 1'b0, 0, 6, 1'b1, 32'(t * 16), 0);
            step();
        end
        idle();
        drive_cdb(6, 32'h66);
        for (int t = 1; t <= 3; t++) sb.push_back(mk_op(TW'(t), 32'h66, 32'(t * 16)));
        step(); idle();
        chk1("t3_wake_edge", o_valid, 1'b0);
        for (int t = 1; t <= 3; t++) begin
            step();
            chk1("t3_valid", o_valid, 1'b1);
            chk32("t3_order", 32'(o_tag), 32'(t));
        end
        step();
        chk1("t3_drained", o_valid, 1'b0);

        // Fill, ignore dispatch while full, free one slot and refill it.
        for (int i = 0; i < 4; i++) begin
            drive_disp(TW'(10 + i), 1'b0, 0, TW'(20 + i), 1'b1, 32'h100 + 32'(i), 0);
            step();
        end
        idle();
        chk1("t4_full_stall", o_rs_stall, 1'b1);
        drive_disp(14, 1'b1, 32'hE, 0, 1'b1, 32'hE, 0);
        step(); step(); idle();
        chk1("t4_still_stall", o_rs_stall, 1'b1);
        drive_cdb(22, 32'hC);
        sb.push_back(mk_op(12, 32'hC, 32'h102));
        step(); idle();
        chk1("t4_stall_at_wake", o_rs_stall, 1'b1);
        step();
        chk1("t4_issue_valid", o_valid, 1'b1);
        chk32("t4_issue_tag", 32'(o_tag), 32'd12);
        chk1("t4_stall_drop", o_rs_stall, 1'b0);
        drive_disp(15, 1'b0, 0, 20, 1'b1, 32'h1F, 0);
        step(); idle();
        chk1("t4_refill_stall", o_rs_stall, 1'b1);
        drive_cdb(20, 32'h20);
        sb.push_back(mk_op(10, 32'h20, 32'h100));
        sb.push_back(mk_op(15, 32'h20, 32'h1F));
        step(); idle();
        step();
        chk32("t4_older_first", 32'(o_tag), 32'd10);
        step();
        chk32("t4_youngest", 32'(o_tag), 32'd15);
        drive_cdb(21, 32'h21);
        sb.push_back(mk_op(11, 32'h21, 32'h101));
        step();
        drive_cdb(23, 32'h23);
        sb.push_back(mk_op(13, 32'h23, 32'h103));
        step(); idle();
        chk32("t4_tag11", 32'(o_tag), 32'd11);
        step();
        chk32("t4_tag13", 32'(o_tag), 32'd13);
        step();
        chk1("t4_empty", o_valid, 1'b0);

        // Same-cycle CDB bypass into a dispatching source.
        drive_disp(16, 1'b1, 32'h3, 0, 1'b0, 0, 8);
        drive_cdb(8, 32'hFF);
        sb.push_back(mk_op(16, 32'h3, 32'hFF));
        step(); idle();
        step();
        chk1("t5_valid", o_valid, 1'b1);
        chk32("t5_src_b", o_src_b, 32'hFF);
        step();

        // Flush (r=0) then reset (r=1) with dispatch and CDB in the same cycle.
        for (int r = 0; r < 2; r++) begin
            for (int t = 1; t <= 3; t++) begin
                drive_disp(TW'(t), 1'b0, 0, 7, 1'b1, 0, 0);
                step();
            end
            idle();
            drive_disp(5, 1'b1, 1, 0, 1'b1, 1, 0);
            drive_cdb(7, 32'h77);
            if (r == 0) i_flush = 1'b1;
            else        rst     = 1'b1;
            step(); idle();
            rst = 1'b0;
            chk1("t6_valid", o_valid, 1'b0);
            chk1("t6_stall", o_rs_stall, 1'b0);
            drive_cdb(7, 32'h77);
            step(); idle();
            for (int k = 0; k < 4; k++) begin
                step();
                chk1("t6_quiet", o_valid, 1'b0);
            end
        end

        for (int k = 0; (k < 20) && (sb.size() != 0); k++) step();
        chk32("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ieu_rs.md
Name: ieu_rs

Overview:
- Reservation station and issue scheduler for the integer execution unit.
- Accepts renamed integer ops from dispatch and holds them until both source operands are available.
- Snoops the common data bus (CDB) to wake up waiting operands.
- Issues at most one ready op per cycle, oldest first, to the IEU decode stage. The IEU is fully pipelined, so there is no backpressure from it.

Parameters:
- OPTN_DATA_WIDTH, 32, operand/data width
- OPTN_ADDR_WIDTH, 32, instruction address width
- OPTN_ROB_IDX_WIDTH, 5, ROB tag width
- OPTN_RS_DEPTH, 4, number of entries (>=2, power of two not required)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_flush  in  1  pipeline flush
- i_rs_en  in  1  dispatch valid
- i_rs_opcode  in  `PCYN_OPCODE_WIDTH  opcode
- i_rs_iaddr  in  OPTN_ADDR_WIDTH  instruction address
- i_rs_insn  in  OPTN_DATA_WIDTH  raw instruction
- i_rs_src_a_data / i_rs_src_b_data  in  OPTN_DATA_WIDTH  operand value, meaningful when rdy
- i_rs_src_a_tag / i_rs_src_b_tag  in  OPTN_ROB_IDX_WIDTH  producer tag, meaningful when not rdy
- i_rs_src_a_rdy / i_rs_src_b_rdy  in  1  operand available
- i_rs_dst_tag  in  OPTN_ROB_IDX_WIDTH  destination ROB tag
- o_rs_stall  out  1  RS full, dispatch must hold
- i_cdb_en  in  1  CDB broadcast valid
- i_cdb_tag  in  OPTN_ROB_IDX_WIDTH  CDB tag
- i_cdb_data  in  OPTN_DATA_WIDTH  CDB value
- o_opcode / o_iaddr / o_insn / o_src_a / o_src_b / o_tag  out  (widths as inputs)  issued op to IEU decode
- o_valid  out  1  issue valid

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset or flush (registered, takes effect at the next edge):
  - all entry valid bits cleared, o_valid=0.
  - other outputs don't-care (not reset).
  - any dispatch or CDB capture in that cycle is dropped.
  - o_rs_stall=0 the following cycle.
- Entry state: valid, opcode, iaddr, insn, dst tag, and per source {rdy, tag, data}.
- Dispatch:
  - when i_rs_en & ~o_rs_stall, write the lowest-index invalid entry.
  - i_rs_en while o_rs_stall=1 is ignored; dispatch holds its op.
  - Same-cycle bypass: if i_cdb_en and a not-ready dispatched source tag == i_cdb_tag, store i_cdb_data with rdy=1.
- o_rs_stall: combinational, = all entries valid in the current cycle. An issue in the same cycle does not deassert it (conservative).
- Wakeup: for each valid entry and each not-ready source with tag == i_cdb_tag while i_cdb_en, capture data and set rdy at the next edge. Both sources may wake on the same broadcast.
- Ready: entry valid & src_a.rdy & src_b.rdy, computed from registered state only.
  - A woken entry is eligible the cycle after the CDB broadcast.
  - Earliest dispatch-to-o_valid latency is 2 edges (dispatch edge, then issue edge).
- Select: oldest ready entry, by age matrix.
  - age[i][j]=1 means i is older than j.
  - On dispatch to slot k: row k cleared, column k set for all other valid entries.
- Issue:
  - the selected entry's fields are registered onto o_* with o_valid=1, and the entry is invalidated at the same edge.
  - No ready entry -> o_valid=0.
  - At most one issue per cycle.
- Simultaneous dispatch and issue: allowed. The freed slot is reusable from the next cycle; the new op is always younger than all existing entries.
- CDB tag matching a dispatching entry's dst: no effect.

Decomposition:
- Entry struct typedef and RS index width macro go in procyon_constants.svh, alongside the existing PCYN macros.
- One sub-module: ieu_rs_age_matrix. Inputs: dispatch slot one-hot, valid vector, ready vector. Output: one-hot oldest-ready grant.

Test Plan:
- Dispatch op tag 3, both src rdy (a=5, b=7) into empty RS -> two edges later o_valid=1, o_tag=3, o_src_a=5, o_src_b=7; the next cycle o_valid=0.
- Dispatch tag 4 with src_a waiting on tag 9; CDB tag 9 data 0x1234 two cycles later -> issue one cycle after the broadcast with o_src_a=0x1234.
- Dispatch tags 1, 2, 3 all waiting on tag 6; single CDB tag 6 -> issues in order 1, 2, 3 on consecutive cycles.
- Fill 4 entries, all not ready -> o_rs_stall=1; a fifth dispatch is ignored. Wake one entry -> it issues, o_rs_stall drops, the next dispatch fills the freed slot and is youngest.
- Dispatch with src_b tag 8 in the same cycle as CDB tag 8 data 0xFF -> stored ready; issues with o_src_b=0xFF.
- With 3 entries pending, assert i_flush together with dispatch and CDB -> next cycle o_valid=0, o_rs_stall=0, and nothing issues afterwards. Repeat with rst -> identical result.
